// File: rtl/evm_ballot_ctrl_pkg.sv
// Shared types and width helpers for the ballot controller.
// Holds the FSM state encoding and the IDX_W/TOT_W derivations.
package evm_ballot_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_LOCKED,
    S_SCAN,
    S_DONE
  } state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // N parties of at most 2^CNT_W-1 votes each fit in CNT_W+IDX_W bits.
  function automatic int tot_w(input int cnt_w, input int n);
    return cnt_w + idx_w(n);
  endfunction

endpackage

// File: rtl/evm_ballot_ctrl_scan.sv
// Running-max scan over the tallies, one party index per start cycle.
// Ports: clk, rst, start, idx, cnt in; winner, tie, scan_done out.
module evm_tally_scan #(
  parameter int N_PARTY = 4,
  parameter int CNT_W   = 7,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] idx,
  input  logic [CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] winner,
  output logic             tie,
  output logic             scan_done
);

  logic [CNT_W-1:0] max_q;

  assign scan_done = start && (idx == IDX_W'(N_PARTY - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q  <= '0;
      winner <= '0;
      tie    <= 1'b0;
    end else if (start) begin
      if (idx == '0) begin
        max_q  <= cnt;
        winner <= '0;
        tie    <= 1'b0;
      end else if (cnt > max_q) begin
        max_q  <= cnt;
        winner <= idx;
        tie    <= 1'b0;
      end else if (cnt == max_q) begin
        tie    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Voting machine controller: session FSM, per-party tallies, result scan.
// Ports: session/cast inputs; ready, ack, tallies and scan results out.
module evm_ballot_ctrl
  import evm_ballot_ctrl_pkg::*;
#(
  parameter  int N_PARTY = 4,
  parameter  int CNT_W   = 7,
  localparam int IDX_W   = idx_w(N_PARTY),
  localparam int TOT_W   = tot_w(CNT_W, N_PARTY)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     session_open,
  input  logic                     session_close,
  input  logic [N_PARTY-1:0]       voter_switch,
  input  logic                     cast,
  output logic                     ready,
  output logic [N_PARTY-1:0]       vote_indicator,
  output logic                     invalid,
  output logic [N_PARTY*CNT_W-1:0] counts,
  output logic [TOT_W-1:0]         total,
  output logic [N_PARTY-1:0]       sat,
  output logic                     done,
  output logic [IDX_W-1:0]         winner,
  output logic                     tie
);

  state_t state;
  state_t state_nx;

  logic             clr;
  logic             accept;
  logic             reject;
  logic             scan_go;
  logic             scan_last;
  logic             scan_rst;
  logic             one_hot;
  logic             hit_full;
  logic [IDX_W-1:0] scan_idx;
  logic [N_PARTY-1:0] full;
  logic [CNT_W-1:0] cnt_arr [N_PARTY];
  logic [CNT_W-1:0] cnt_sel;

  assign one_hot = (voter_switch != '0) &&
    ((voter_switch & (voter_switch - N_PARTY'(1))) == '0);

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    accept   = 1'b0;
    reject   = 1'b0;
    scan_go  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (session_open) begin
          clr      = 1'b1;
          state_nx = S_OPEN;
        end
      end
      S_OPEN: begin
        // close wins over a same-cycle cast
        if (session_close) begin
          state_nx = S_SCAN;
        end else if (cast) begin
          accept   = one_hot;
          reject   = !one_hot;
          state_nx = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (session_close) begin
          state_nx = S_SCAN;
        end else if (!cast) begin
          state_nx = S_OPEN;
        end
      end
      S_SCAN: begin
        scan_go = 1'b1;
        if (scan_last) begin
          state_nx = S_DONE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ready          <= 1'b0;
      done           <= 1'b0;
      invalid        <= 1'b0;
      vote_indicator <= '0;
      scan_idx       <= '0;
    end else begin
      state          <= state_nx;
      ready          <= (state_nx == S_OPEN);
      done           <= (state_nx == S_DONE);
      invalid        <= reject;
      vote_indicator <= accept ? voter_switch : '0;
      scan_idx       <= scan_go ? scan_idx + IDX_W'(1) : '0;
    end
  end

  for (genvar i = 0; i < N_PARTY; i++) begin : g_cnt
    logic [CNT_W-1:0] c;
    logic             s;

    assign full[i]    = &c;
    assign cnt_arr[i] = c;
    assign sat[i]     = s;
    assign counts[i*CNT_W +: CNT_W] = c;

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        c <= '0;
        s <= 1'b0;
      end else if (accept && voter_switch[i]) begin
        if (full[i]) begin
          s <= 1'b1;
        end else begin
          c <= c + CNT_W'(1);
        end
      end
    end
  end

  // a vote into a saturated counter is acknowledged but not totalled
  assign hit_full = |(voter_switch & full);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      total <= '0;
    end else if (accept && !hit_full) begin
      total <= total + TOT_W'(1);
    end
  end

  assign cnt_sel  = cnt_arr[scan_idx];
  assign scan_rst = rst || clr;

  evm_tally_scan #(
    .N_PARTY (N_PARTY),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_scan (
    .clk       (clk),
    .rst       (scan_rst),
    .start     (scan_go),
    .idx       (scan_idx),
    .cnt       (cnt_sel),
    .winner    (winner),
    .tie       (tie),
    .scan_done (scan_last)
  );

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Bench for evm_ballot_ctrl: two instances (CNT_W 7 and 3) share stimulus
// and are checked every cycle against a behavioural ballot-box model.
module tb_evm_ballot_ctrl;

  logic clk = 1'b0;
  logic rst, session_open, session_close, cast;
  logic [3:0] voter_switch;

  logic ready_a, invalid_a, done_a, tie_a;
  logic [3:0] vi_a, sat_a;
  logic [27:0] counts_a;
  logic [8:0] total_a;
  logic [1:0] win_a;

  logic ready_b, invalid_b, done_b, tie_b;
  logic [3:0] vi_b, sat_b;
  logic [11:0] counts_b;
  logic [4:0] total_b;
  logic [1:0] win_b;

  int total_n = 0;
  int bad_n = 0;

  always #5 clk = ~clk;

  evm_ballot_ctrl #(.N_PARTY(4), .CNT_W(7)) dut_a (
    .clk(clk), .rst(rst), .session_open(session_open),
    .session_close(session_close), .voter_switch(voter_switch),
    .cast(cast), .ready(ready_a), .vote_indicator(vi_a),
    .invalid(invalid_a), .counts(counts_a), .total(total_a),
    .sat(sat_a), .done(done_a), .winner(win_a), .tie(tie_a)
  );

  evm_ballot_ctrl #(.N_PARTY(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .session_open(session_open),
    .session_close(session_close), .voter_switch(voter_switch),
    .cast(cast), .ready(ready_b), .vote_indicator(vi_b),
    .invalid(invalid_b), .counts(counts_b), .total(total_b),
    .sat(sat_b), .done(done_b), .winner(win_b), .tie(tie_b)
  );

  // model: mode 0 idle, 1 accepting, 2 awaiting release, 3 scanning, 4 result
  int mode = 0;
  int left = 0;
  int m_cnt [2][4];
  int m_tot [2];
  logic [3:0] m_sat [2];
  int m_win [2];
  bit m_tie [2];
  logic [3:0] m_vi;
  bit m_inv, m_done;
  int cmax [2] = '{127, 7};
  int pulses [2] = '{0, 0};
  int inv_pulses = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
      m_tot[k] = 0;
      m_sat[k] = '0;
      m_win[k] = 0;
      m_tie[k] = 0;
    end
    m_done = 0;
  endtask

  task automatic m_result();
    for (int k = 0; k < 2; k++) begin
      int mx, nmx;
      mx = -1;
      nmx = 0;
      for (int i = 0; i < 4; i++) if (m_cnt[k][i] > mx) mx = m_cnt[k][i];
      m_win[k] = -1;
      for (int i = 0; i < 4; i++) begin
        if (m_cnt[k][i] == mx) begin
          nmx++;
          if (m_win[k] < 0) m_win[k] = i;
        end
      end
      m_tie[k] = (nmx >= 2);
    end
    m_done = 1;
  endtask

  task automatic m_step(bit r, bit op, bit cl, bit ca, logic [3:0] sw);
    m_vi = '0;
    m_inv = 0;
    if (r) begin
      mode = 0;
      m_clear();
    end else begin
      case (mode)
        0, 4: if (op) begin mode = 1; m_clear(); end
        1: begin
          if (cl) begin
            mode = 3; left = 4;
          end else if (ca) begin
            mode = 2;
            if ($countones(sw) == 1) begin
              m_vi = sw;
              for (int k = 0; k < 2; k++)
                for (int i = 0; i < 4; i++)
                  if (sw[i]) begin
                    if (m_cnt[k][i] == cmax[k]) m_sat[k][i] = 1'b1;
                    else begin m_cnt[k][i]++; m_tot[k]++; end
                  end
            end else begin
              m_inv = 1;
            end
          end
        end
        2: begin
          if (cl) begin mode = 3; left = 4; end
          else if (!ca) mode = 1;
        end
        3: begin
          left--;
          if (left == 0) begin mode = 4; m_result(); end
        end
        default: mode = 0;
      endcase
    end
  endtask

  initial begin
    forever begin
      bit r, op, cl, ca;
      logic [3:0] sw;
      @(posedge clk);
      r = rst; op = session_open; cl = session_close;
      ca = cast; sw = voter_switch;
      #1;
      m_step(r, op, cl, ca, sw);
      if (vi_a != 0) pulses[0]++;
      if (vi_b != 0) pulses[1]++;
      if (invalid_a) inv_pulses++;
      for (int k = 0; k < 2; k++) begin
        string p;
        p = (k == 0) ? "a." : "b.";
        chk({p, "ready"}, k ? ready_b : ready_a, mode == 1);
        chk({p, "vi"}, k ? vi_b : vi_a, m_vi);
        chk({p, "invalid"}, k ? invalid_b : invalid_a, m_inv);
        chk({p, "done"}, k ? done_b : done_a, m_done);
        chk({p, "total"}, k ? total_b : total_a, m_tot[k]);
        chk({p, "sat"}, k ? sat_b : sat_a, m_sat[k]);
        for (int i = 0; i < 4; i++)
          chk($sformatf("%scnt%0d", p, i),
              k ? counts_b[i*3 +: 3] : counts_a[i*7 +: 7], m_cnt[k][i]);
        if (mode != 3) begin
          chk({p, "winner"}, k ? win_b : win_a, m_win[k]);
          chk({p, "tie"}, k ? tie_b : tie_a, m_tie[k]);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_open();
    session_open = 1; tick(); session_open = 0;
  endtask

  task automatic vote(logic [3:0] sw);
    voter_switch = sw; cast = 1; tick();
    cast = 0; tick();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_a && n < 20) begin tick(); n++; end
    chk("done_timeout", done_a, 1);
  endtask

  task automatic do_close(output int n);
    session_close = 1; tick(); session_close = 0;
    wait_done(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0, p1, i0;
    rst = 1; session_open = 0; session_close = 0;
    cast = 0; voter_switch = '0;
    tick(2);
    chk("rst_ready", ready_a, 0);
    chk("rst_total", total_a, 0);
    chk("rst_done", done_a, 0);
    rst = 0;
    tick();

    do_open();
    chk("open_ready", ready_a, 1);
    vote(4'b0001); vote(4'b0010); vote(4'b0010); vote(4'b1000);
    do_close(n);
    chk("lit_scan_lat", n, 4);
    chk("lit_c0", counts_a[6:0], 1);
    chk("lit_c1", counts_a[13:7], 2);
    chk("lit_c2", counts_a[20:14], 0);
    chk("lit_c3", counts_a[27:21], 1);
    chk("lit_total", total_a, 4);
    chk("lit_winner", win_a, 1);
    chk("lit_tie", tie_a, 0);

    do_open();
    p0 = pulses[0];
    voter_switch = 4'b0100; cast = 1; tick(10);
    cast = 0; tick();
    chk("hold_c2", counts_a[20:14], 1);
    chk("hold_pulses", pulses[0] - p0, 1);
    vote(4'b0100);
    chk("repress_c2", counts_a[20:14], 2);

    p0 = pulses[0]; i0 = inv_pulses;
    vote(4'b0000); vote(4'b0110);
    chk("inv_pulses", inv_pulses - i0, 2);
    chk("inv_no_vi", pulses[0] - p0, 0);
    chk("inv_total", total_a, 2);
    do_close(n);

    do_open();
    p1 = pulses[1];
    repeat (9) vote(4'b1000);
    chk("sat_c3", counts_b[11:9], 7);
    chk("sat_total", total_b, 7);
    chk("sat_flag", sat_b[3], 1);
    chk("sat_pulses", pulses[1] - p1, 9);
    chk("sat_wide_c3", counts_a[27:21], 9);
    do_close(n);

    do_open();
    vote(4'b0001); vote(4'b0001); vote(4'b0100);
    vote(4'b0100); vote(4'b1000);
    session_close = 1; cast = 1; voter_switch = 4'b0010; tick();
    session_close = 0;
    wait_done(n);
    cast = 0; tick();
    chk("tie_winner", win_a, 0);
    chk("tie_flag", tie_a, 1);
    chk("tie_c1", counts_a[13:7], 0);
    chk("tie_total", total_a, 5);

    do_open();
    vote(4'b0001);
    session_close = 1; tick(); session_close = 0;
    tick(2);
    rst = 1; tick(); rst = 0;
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_counts", counts_a, 0);
    chk("mid_rst_winner", win_a, 0);
    chk("mid_rst_tie", tie_a, 0);
    do_open();
    do_close(n);
    chk("empty_winner", win_a, 0);
    chk("empty_tie", tie_a, 1);

    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      session_open = ($urandom_range(0, 7) == 0);
      session_close = ($urandom_range(0, 40) == 0);
      cast = $urandom_range(0, 1);
      if ($urandom_range(0, 3) != 0)
        voter_switch = 4'(1 << $urandom_range(0, 3));
      else
        voter_switch = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 0; session_open = 0; session_close = 0; cast = 0;
    tick(8);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/evm_ballot_ctrl.md
EVM_BALLOT_CTRL -- requirements
Module: evm_ballot_ctrl

Interface
REQ-001 The block SHALL have parameter N_PARTY, default 4, number of parties, legal range 2..8.
REQ-002 The block SHALL have parameter CNT_W, default 7, per-party counter width.
REQ-003 The block SHALL derive local constants IDX_W = clog2(N_PARTY) and TOT_W = CNT_W + IDX_W.
REQ-004 The block SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port session_open  in  1  start a new session and clear the tallies.
REQ-007 The block SHALL have port session_close  in  1  end voting and start the result scan.
REQ-008 The block SHALL have port voter_switch  in  N_PARTY  party selection, legal only when one-hot.
REQ-009 The block SHALL have port cast  in  1  voter cast button, level-sensitive.
REQ-010 The block SHALL have port ready  out  1  machine accepting a ballot.
REQ-011 The block SHALL have port vote_indicator  out  N_PARTY  one-cycle one-hot acknowledge of the accepted party.
REQ-012 The block SHALL have port invalid  out  1  one-cycle pulse on a rejected ballot.
REQ-013 The block SHALL have port counts  out  N_PARTY*CNT_W  packed tallies, party i at bits [i*CNT_W +: CNT_W].
REQ-014 The block SHALL have port total  out  TOT_W  sum of counted votes.
REQ-015 The block SHALL have port sat  out  N_PARTY  per-party saturation flag, sticky.
REQ-016 The block SHALL have ports done  out  1, winner  out  IDX_W and tie  out  1, carrying the scan results.

Function
REQ-017 The FSM SHALL have states IDLE, OPEN, LOCKED, SCAN and DONE; every output is registered.
REQ-018 session_open in IDLE or DONE SHALL clear counts, total, sat, winner, tie and done, then enter OPEN; in any other state it is ignored.
REQ-019 ready SHALL be 1 only in OPEN.
REQ-020 In OPEN, cast=1 with a one-hot voter_switch SHALL, on the next edge:
- increment the selected counter and total;
- drive vote_indicator=voter_switch for exactly one cycle;
- enter LOCKED.
REQ-021 In OPEN, cast=1 with a zero or multi-hot voter_switch SHALL pulse invalid for one cycle, change no tally and enter LOCKED.
REQ-022 LOCKED SHALL return to OPEN on the first cycle with cast=0, so that a held button counts at most once.
REQ-023 A valid vote to a counter at 2^CNT_W-1 SHALL:
- leave the counter and total unchanged;
- set sat[i];
- still pulse vote_indicator.
REQ-024 session_close in OPEN or LOCKED SHALL enter SCAN; in the same cycle it SHALL override cast, so that ballot is neither counted nor flagged.
REQ-025 SCAN SHALL take exactly N_PARTY cycles and visit party indices 0..N_PARTY-1 in order.
- Strictly greater count: replace the running max, set winner to that index, clear tie.
- Equal count: set tie.
- Party 0 initialises the running max.
REQ-026 After SCAN the block SHALL enter DONE with done=1 and winner/tie stable; winner is the lowest index holding the max count.
REQ-027 All-zero tallies SHALL give winner=0 and tie=1.
REQ-028 Tallies SHALL change only in OPEN; cast is ignored in IDLE, SCAN and DONE.
REQ-029 total SHALL always equal the sum of counts; it cannot overflow by construction of TOT_W.

Reset
REQ-030 rst=1 SHALL, at the next edge, force IDLE and zero every output and counter, with precedence over all other inputs.
REQ-031 rst asserted mid-SCAN or in LOCKED SHALL abandon the operation with no partial result retained.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding and the IDX_W/TOT_W derivation functions.
REQ-033 The running-max comparison SHALL be a sub-module evm_tally_scan, with these ports:
- inputs: start, a count-select index and the selected count;
- outputs: winner, tie and scan_done.
REQ-034 Counters SHALL be a generate loop over N_PARTY; no per-party hand-written always blocks.

Verification
REQ-035 N_PARTY=4, CNT_W=7: open, then cast 0001/0010/0010/1000, then close -> counts 1,2,0,1; total 4; winner 1; tie 0; done one cycle after the 4-cycle scan.
REQ-036 cast held high 10 cycles with 0100 -> count[2]=1 and a single vote_indicator pulse; a release and re-press gives count[2]=2.
REQ-037 cast with 0000 and with 0110 -> two invalid pulses, all tallies unchanged, no vote_indicator.
REQ-038 CNT_W=3: 9 valid votes to party 3 -> count[3]=7, total=7, sat[3]=1 and 9 vote_indicator pulses.
REQ-039 Votes 2,0,2,1 per party, then close -> winner 0, tie 1; close and cast in the same cycle -> that ballot is not counted.
REQ-040 rst pulsed during SCAN -> next cycle IDLE with all outputs 0; a later open/close with no votes -> winner 0, tie 1.
